// File: rtl/aht10_frame_tx_if.sv
// aht10_frame_tx_if
// Bundles the sensor-sample input, the UART byte handshake and the frame
// status outputs of aht10_frame_tx into one interface.
//   data_vld    : one-cycle pulse, hum/tem valid
//   hum, tem    : 20-bit raw AHT10 humidity / temperature
//   tx_busy     : UART transmitter busy (from the UART)
//   tx_byte_vld : one-cycle send request to the UART
//   tx_byte     : byte to send, held until the next request
//   frame_busy  : high from frame accept until frame end
//   frame_done  : one-cycle pulse at frame end
//   drop        : one-cycle pulse when a sample arrives mid-frame
// Modports: slave = framer view, master = sample source / UART side view.
interface aht10_frame_tx_if;
  logic        data_vld;
  logic [19:0] hum;
  logic [19:0] tem;
  logic        tx_busy;
  logic        tx_byte_vld;
  logic [7:0]  tx_byte;
  logic        frame_busy;
  logic        frame_done;
  logic        drop;

  modport slave (
    input  data_vld, hum, tem, tx_busy,
    output tx_byte_vld, tx_byte, frame_busy, frame_done, drop
  );

  modport master (
    output data_vld, hum, tem, tx_busy,
    input  tx_byte_vld, tx_byte, frame_busy, frame_done, drop
  );
endinterface

// File: rtl/aht10_frame_tx.sv
// aht10_frame_tx
// Packs one AHT10 sample (20-bit humidity + 20-bit temperature) into a byte
// frame and feeds it to a UART transmitter one byte at a time:
//   HEADER, hum[19:12], hum[11:4], {hum[3:0],tem[19:16]}, tem[15:8], tem[7:0]
//   [, checksum]
// Optional feature macro: AHT10_FRAME_CHKSUM_EN. When defined, a 7th byte is
// appended holding the modulo-256 sum of the five data bytes (HEADER
// excluded). When undefined the frame is 6 bytes and no checksum logic exists.
// Parameters:
//   HEADER : frame start byte (default 8'hAA)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : aht10_frame_tx_if.slave (sample in, UART handshake, frame status)
module aht10_frame_tx #(
  parameter logic [7:0] HEADER = 8'hAA
) (
  input  logic             clk,
  input  logic             rst_n,
  aht10_frame_tx_if.slave  bus
);

`ifdef AHT10_FRAME_CHKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [39:0] shadow;   // {hum, tem} captured at accept
  logic [7:0]  cur_byte;

`ifdef AHT10_FRAME_CHKSUM_EN
  logic [7:0] chksum;
  logic [7:0] new_sum;

  // Summed straight from the inputs so the checksum is ready in the same
  // cycle the sample is latched; 8-bit result discards the carries.
  always_comb begin
    new_sum = bus.hum[19:12] + bus.hum[11:4] + {bus.hum[3:0], bus.tem[19:16]}
            + bus.tem[15:8] + bus.tem[7:0];
  end
`endif

  // Byte selected by the current index; the data bytes are fixed slices of
  // the shadow register.
  always_comb begin
    cur_byte = HEADER;
    case (idx)
      3'd1:    cur_byte = shadow[39:32];
      3'd2:    cur_byte = shadow[31:24];
      3'd3:    cur_byte = shadow[23:16];
      3'd4:    cur_byte = shadow[15:8];
      3'd5:    cur_byte = shadow[7:0];
`ifdef AHT10_FRAME_CHKSUM_EN
      3'd6:    cur_byte = chksum;
`endif
      default: cur_byte = HEADER;
    endcase
  end

  // Frame FSM. All outputs are registered; the request is issued from SEND,
  // so it appears one cycle after the state is entered, which also widens
  // the gap after tx_busy falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 3'd0;
      shadow          <= 40'd0;
`ifdef AHT10_FRAME_CHKSUM_EN
      chksum          <= 8'd0;
`endif
      bus.tx_byte_vld <= 1'b0;
      bus.tx_byte     <= 8'h00;
      bus.frame_busy  <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.drop        <= 1'b0;
    end else begin
      bus.tx_byte_vld <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.drop        <= 1'b0;

      // Any sample arriving outside IDLE (DONE included) is discarded.
      if (state != IDLE && bus.data_vld) begin
        bus.drop <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.data_vld) begin
            shadow         <= {bus.hum, bus.tem};
`ifdef AHT10_FRAME_CHKSUM_EN
            chksum         <= new_sum;
`endif
            idx            <= 3'd0;
            bus.frame_busy <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          // Guard keeps a request from ever overlapping a busy UART.
          if (!bus.tx_busy) begin
            bus.tx_byte     <= cur_byte;
            bus.tx_byte_vld <= 1'b1;
            state           <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (idx == LAST_IDX) begin
              bus.frame_done <= 1'b1;
              bus.frame_busy <= 1'b0;
              state          <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= SEND;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aht10_frame_tx.sv
// tb_aht10_frame_tx
// Scoreboard bench for aht10_frame_tx. Stimulus pushes hand-computed frame
// bytes into a queue; an independent monitor pops and compares on every
// tx_byte_vld, and counts frame_done / drop pulses. A small UART model
// raises tx_busy the cycle after a request for a fixed number of cycles,
// optionally after a one-shot stall.
// Build with or without +define+AHT10_FRAME_CHKSUM_EN.
module tb_aht10_frame_tx;

`ifdef AHT10_FRAME_CHKSUM_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif
  localparam int BUSY_CYCLES = 10;

  logic clk;
  logic rst_n;

  aht10_frame_tx_if ifc ();

  aht10_frame_tx #(.HEADER(8'hAA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks;
  int fails;
  int vld_count;
  int done_count;
  int drop_count;
  bit stall_once;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Pulse data_vld for one cycle; when the frame should be accepted, queue
  // the first FRAME_LEN bytes of the hand-computed 7-byte vector.
  task automatic applyStimulus(input logic [19:0] h, input logic [19:0] t,
                               input logic [55:0] exp_bytes, input bit expect_accept);
    @(posedge clk);
    #1;
    if (expect_accept) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        exp_q.push_back(exp_bytes[55 - 8*i -: 8]);
      end
    end
    ifc.hum      = h;
    ifc.tem      = t;
    ifc.data_vld = 1'b1;
    @(posedge clk);
    #1;
    ifc.data_vld = 1'b0;
  endtask

  task automatic waitDone(input int target, input string name);
    int n;
    n = 0;
    while (done_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done_count"}, done_count, target);
    checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    checkOutput({name, "_busy_after"}, ifc.frame_busy, 1'b0);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_tx_byte_vld"}, ifc.tx_byte_vld, 1'b0);
    checkOutput({name, "_tx_byte"}, ifc.tx_byte, 8'h00);
    checkOutput({name, "_frame_busy"}, ifc.frame_busy, 1'b0);
    checkOutput({name, "_frame_done"}, ifc.frame_done, 1'b0);
    checkOutput({name, "_drop"}, ifc.drop, 1'b0);
  endtask

  // UART model: busy rises the cycle after a request and stays high for
  // BUSY_CYCLES cycles; stall_once delays the start by 20 cycles once.
  initial begin
    ifc.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ifc.tx_busy = 1'b0;
      end else if (ifc.tx_byte_vld && !ifc.tx_busy) begin
        if (stall_once) begin
          stall_once = 1'b0;
          repeat (20) @(posedge clk);
        end
        @(posedge clk);
        #1 ifc.tx_busy = 1'b1;
        repeat (BUSY_CYCLES) @(posedge clk);
        #1 ifc.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on every request; frame_done and drop counted.
  initial begin
    logic [7:0] exp;
    bit prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.tx_byte_vld) begin
        vld_count++;
        checkOutput("vld_while_busy", ifc.tx_busy, 1'b0);
        checkOutput("vld_repeated", prev_vld, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_tx_byte_vld: got byte 0x%0h, expected no request (t=%0t)",
                   ifc.tx_byte, $time);
        end else begin
          exp = exp_q.pop_front();
          checkOutput("tx_byte", ifc.tx_byte, exp);
        end
      end
      prev_vld = ifc.tx_byte_vld;
      if (ifc.frame_done) begin
        done_count++;
        checkOutput("frame_busy_at_done", ifc.frame_busy, 1'b0);
      end
      if (ifc.drop) drop_count++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int base;
    checks       = 0;
    fails        = 0;
    vld_count    = 0;
    done_count   = 0;
    drop_count   = 0;
    stall_once   = 1'b0;
    ifc.data_vld = 1'b0;
    ifc.hum      = 20'h0;
    ifc.tem      = 20'h0;
    rst_n        = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    #1 rst_n = 1'b1;

    // Basic frame.
    applyStimulus(20'h12345, 20'h6789A, 56'hAA_12_34_56_78_9A_AE, 1'b1);
    @(negedge clk);
    checkOutput("frame_busy_after_accept", ifc.frame_busy, 1'b1);
    waitDone(1, "frame_a");

    // Second sample 5 cycles after accept is dropped, frame unchanged.
    applyStimulus(20'h12345, 20'h6789A, 56'hAA_12_34_56_78_9A_AE, 1'b1);
    repeat (4) @(posedge clk);
    applyStimulus(20'hFFFFF, 20'hFFFFF, 56'h0, 1'b0);
    waitDone(2, "drop");
    checkOutput("drop_count", drop_count, 1);

    // Stalled UART: DUT must sit in WAIT_HI without re-requesting.
    stall_once = 1'b1;
    base = vld_count;
    applyStimulus(20'h0F0F0, 20'h55AA5, 56'hAA_0F_0F_05_5A_A5_22, 1'b1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_single_request", vld_count - base, 1);
    checkOutput("stall_frame_busy", ifc.frame_busy, 1'b1);
    waitDone(3, "stall");

    // All ones: checksum carries discarded.
    applyStimulus(20'hFFFFF, 20'hFFFFF, 56'hAA_FF_FF_FF_FF_FF_FB, 1'b1);
    waitDone(4, "all_ones");

    // Reset during WAIT_LO of the third byte.
    base = vld_count;
    applyStimulus(20'h12345, 20'h6789A, 56'hAA_12_34_56_78_9A_AE, 1'b1);
    n = 0;
    while (vld_count < base + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("third_byte_reached", vld_count - base, 3);
    n = 0;
    while (!ifc.tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkReset("mid_frame_reset");
    checkOutput("abandoned_bytes", exp_q.size(), FRAME_LEN - 3);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (ifc.tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("uart_idle_after_reset", ifc.tx_busy, 1'b0);
    applyStimulus(20'h12345, 20'h6789A, 56'hAA_12_34_56_78_9A_AE, 1'b1);
    waitDone(5, "after_reset");
    checkOutput("total_drops", drop_count, 1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
